uart_io: RTL and testbench

Byte-oriented serial I/O unit that terminates the execute stage's UART request ports (OUTB write, INB read) and drives the board's 8N1 serial pins. It buffers transmit and receive bytes in small FIFOs, so OUTB usually completes in one cycle and INB completes as soon as a byte is buffered. It sits directly downstream of the execute stage's `uart_*` ports and is the only consumer of them.

---
 rtl/uart_pkg.sv | 14 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/uart_io.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_io.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_io serial unit: FSM state encoding used by
// both the transmitter and the receiver, plus the default bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int CLK_PER_BIT_DEFAULT = 868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head entry
// whenever the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH   = 8,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [2**FIFO_AW];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                     (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_io.sv
// 8N1 UART terminating the execute stage's OUTB/INB request ports, with
// TX and RX byte FIFOs between the request latches and the serial FSMs.
module uart_io
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
    parameter int FIFO_AW     = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_wenable,
    input  logic [31:0] uart_wd,
    output logic        uart_wdone,
    input  logic        uart_renable,
    output logic        uart_rdone,
    output logic [31:0] uart_rd,
    output logic        txd,
    input  logic        rxd,
    output logic        rx_overrun,
    output logic        frame_err
);

    localparam int            CW       = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);

    logic        wr_pend, wr_req, rd_pend, rd_req;
    logic [7:0]  wr_byte, tx_din, tx_dout, rx_dout;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic        unused_wd;

    uart_state_t   tx_state, tx_state_n;
    logic [CW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_bit, tx_bit_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          txd_n;

    uart_state_t   rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_bit, rx_bit_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_s1, rx_s2, rx_prev;
    logic          set_ovr, set_ferr;

    assign unused_wd = ^uart_wd[31:8];

    // A request is serviced in the cycle it arrives when the FIFO allows it.
    assign wr_req  = wr_pend || uart_wenable;
    assign tx_din  = uart_wenable ? uart_wd[7:0] : wr_byte;
    assign tx_push = wr_req && (!tx_full || tx_pop);
    assign rd_req  = rd_pend || uart_renable;
    assign rx_pop  = rd_req && !rx_empty;

    sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rstn(rstn), .push(tx_push), .din(tx_din), .pop(tx_pop),
        .full(tx_full), .empty(tx_empty), .dout(tx_dout)
    );

    sync_fifo #(.WIDTH(8), .FIFO_AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rstn(rstn), .push(rx_push), .din(rx_shift), .pop(rx_pop),
        .full(rx_full), .empty(rx_empty), .dout(rx_dout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_pend    <= 1'b0;
            rd_pend    <= 1'b0;
            uart_wdone <= 1'b0;
            uart_rdone <= 1'b0;
            uart_rd    <= '0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            wr_pend    <= wr_req && !tx_push;
            rd_pend    <= rd_req && !rx_pop;
            uart_wdone <= tx_push;
            uart_rdone <= rx_pop;
            if (rx_pop)   uart_rd    <= {24'h0, rx_dout};
            if (set_ovr)  rx_overrun <= 1'b1;
            if (set_ferr) frame_err  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (uart_wenable) wr_byte <= uart_wd[7:0];
        tx_shift <= tx_shift_n;
        rx_shift <= rx_shift_n;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            txd      <= txd_n;
        end
    end

    // txd is registered together with the state it belongs to.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        txd_n      = txd;
        tx_pop     = 1'b0;
        case (tx_state)
            IDLE: begin
                tx_cnt_n = '0;
                txd_n    = 1'b1;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_dout;
                    tx_state_n = START;
                    txd_n      = 1'b0;
                end
            end
            START: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n   = '0;
                    tx_bit_n   = '0;
                    tx_state_n = DATA;
                    txd_n      = tx_shift[0];
                end
            end
            DATA: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n = '0;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit + 1'b1;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        txd_n      = tx_shift[1];
                    end
                end
            end
            STOP: begin
                if (tx_cnt == BIT_END) begin
                    tx_cnt_n = '0;
                    // Chain straight into the next frame so there is no idle gap.
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_dout;
                        tx_state_n = START;
                        txd_n      = 1'b0;
                    end else begin
                        tx_state_n = IDLE;
                        txd_n      = 1'b1;
                    end
                end
            end
            default: tx_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1    <= rxd;
            rx_s2    <= rx_s1;
            rx_prev  <= rx_s2;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_push    = 1'b0;
        set_ovr    = 1'b0;
        set_ferr   = 1'b0;
        case (rx_state)
            IDLE: begin
                rx_cnt_n = '0;
                if (rx_prev && !rx_s2) rx_state_n = START;
            end
            START: begin
                if (rx_cnt == HALF_END) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    rx_state_n = rx_s2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_s2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 1'b1;
                    if (rx_bit == 3'd7) rx_state_n = STOP;
                end
            end
            STOP: begin
                if (rx_cnt == BIT_END) begin
                    rx_cnt_n   = '0;
                    rx_state_n = IDLE;
                    if (!rx_s2)                 set_ferr = 1'b1;
                    else if (rx_full && !rx_pop) set_ovr  = 1'b1;
                    else                        rx_push  = 1'b1;
                end
            end
            default: rx_state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_io.sv
// Randomized scoreboard bench for uart_io with an 8-clock bit period.
module tb_uart_io;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        uart_wenable = 1'b0;
    logic [31:0] uart_wd = '0;
    logic        uart_renable = 1'b0;
    logic        rxd = 1'b1;
    logic        uart_wdone, uart_rdone, txd, rx_overrun, frame_err;
    logic [31:0] uart_rd;

    uart_io #(.CLK_PER_BIT(CPB), .FIFO_AW(4)) dut (
        .clk(clk), .rstn(rstn),
        .uart_wenable(uart_wenable), .uart_wd(uart_wd), .uart_wdone(uart_wdone),
        .uart_renable(uart_renable), .uart_rdone(uart_rdone), .uart_rd(uart_rd),
        .txd(txd), .rxd(rxd), .rx_overrun(rx_overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wd_cnt = 0;
    int rd_cnt = 0;
    int rd_cyc = 0;
    int tx_frames = 0;
    int tx_starts[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] model_rx[$];
    logic model_rd_pend = 1'b0;
    logic model_ovr = 1'b0;
    logic model_ferr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Serial line decoder: samples each bit in its middle and scores the byte.
    initial begin : tx_monitor
        logic       tx_prev;
        logic       ok, s0, sp;
        logic [7:0] b, e;
        int         st;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rstn && tx_prev && !txd) begin
                st = cyc; ok = 1'b1; b = '0;
                repeat (CPB/2) @(negedge clk);
                if (!rstn) ok = 1'b0;
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    if (!rstn) ok = 1'b0;
                    b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                if (!rstn) ok = 1'b0;
                sp = txd;
                if (ok) begin
                    tx_frames++;
                    tx_starts.push_back(st);
                    if (exp_tx.size() == 0) begin
                        total++; bad++;
                        $display("FAIL tx_unexpected: got frame %0h expected none", b);
                    end else begin
                        e = exp_tx.pop_front();
                        chk("tx_frame", {22'h0, sp, b, s0}, {22'h0, 1'b1, e, 1'b0});
                    end
                end
            end
            tx_prev = txd;
        end
    end

    initial begin : rd_monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rstn && uart_rdone) begin
                rd_cnt++;
                rd_cyc = cyc;
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got %0h expected no rdone", uart_rd);
                end else begin
                    e = exp_rd.pop_front();
                    chk("rd_data", uart_rd, {24'h0, e});
                end
            end
        end
    end

    initial begin : wd_monitor
        forever begin
            @(negedge clk);
            if (rstn && uart_wdone) wd_cnt++;
        end
    end

    task automatic do_write(input logic [7:0] b, output int lat, output int wcyc);
        exp_tx.push_back(b);
        uart_wd = {24'($urandom), b};
        uart_wenable = 1'b1;
        @(negedge clk);
        uart_wenable = 1'b0;
        lat = 1;
        while (!uart_wdone && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        wcyc = cyc;
        if (!uart_wdone) chk("wdone_timeout", 32'(uart_wdone), 32'd1);
    endtask

    task automatic do_read();
        if (model_rx.size() > 0) exp_rd.push_back(model_rx.pop_front());
        else model_rd_pend = 1'b1;
        uart_renable = 1'b1;
        @(negedge clk);
        uart_renable = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        if (stop) begin
            if (model_rx.size() < 16) begin
                model_rx.push_back(b);
                if (model_rd_pend) begin
                    exp_rd.push_back(model_rx.pop_front());
                    model_rd_pend = 1'b0;
                end
            end else begin
                model_ovr = 1'b1;
            end
        end else begin
            model_ferr = 1'b1;
        end
        t0 = cyc;
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_frames < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("tx_frames", tx_frames, n);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat, t0, rc, fs, ws, k;
        int wcyc[18];
        logic [7:0] r;

        repeat (3) @(negedge clk);
        chk("rst_txd", 32'(txd), 32'd1);
        chk("rst_wdone", 32'(uart_wdone), 32'd0);
        chk("rst_rdone", 32'(uart_rdone), 32'd0);
        chk("rst_rd", uart_rd, 32'd0);
        chk("rst_ovr", 32'(rx_overrun), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        rstn = 1'b1;
        repeat (3) @(negedge clk);

        // Single write, upper data bits must be ignored.
        exp_tx.push_back(8'h41);
        uart_wd = 32'h1234_5641;
        uart_wenable = 1'b1;
        @(negedge clk);
        uart_wenable = 1'b0;
        chk("single_wdone", 32'(uart_wdone), 32'd1);
        t0 = cyc;
        wait_tx(1, 200);
        chk("single_start_lat", 32'(tx_starts[0] - t0 <= 3), 32'd1);
        repeat (10) @(negedge clk);

        // Back-to-back writes filling the TX FIFO; the last one must stall.
        for (int i = 0; i < 18; i++) begin
            do_write(8'(i), lat, wcyc[i]);
            if (i < 17) chk("bp_lat", lat, 1);
            else        chk("bp_stall", 32'(lat >= 60), 32'd1);
        end
        wait_tx(19, 18 * 80 + 300);
        chk("bp_first_edge", 32'(tx_starts[1] - wcyc[0] <= 3), 32'd1);
        chk("bp_17th_after_pop", 32'(tx_starts[1] < wcyc[16]), 32'd1);
        for (int i = 2; i < 19; i++) chk("bp_no_gap", tx_starts[i] - tx_starts[i-1], 80);

        // Short low glitch, then a frame with a bad stop bit: nothing buffered.
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        send_frame(8'h55, 1'b0, t0);
        repeat (20) @(negedge clk);
        chk("ferr_set", 32'(frame_err), 32'(model_ferr));
        chk("ferr_no_ovr", 32'(rx_overrun), 32'd0);

        // Read before data: must wait for the next good frame.
        rc = rd_cnt;
        do_read();
        repeat (100) @(negedge clk);
        chk("early_no_rdone", rd_cnt, rc);
        send_frame(8'h3C, 1'b1, t0);
        k = 0;
        while (rd_cnt == rc && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk("late_rdone_cnt", rd_cnt, rc + 1);
        chk("late_rdone_when", 32'(rd_cyc - t0 >= 78 && rd_cyc - t0 <= 82), 32'd1);
        repeat (10) @(negedge clk);

        // Read with a byte already waiting.
        send_frame(8'hA5, 1'b1, t0);
        repeat (4) @(negedge clk);
        do_read();
        chk("wait_rd_lat", 32'(uart_rdone), 32'd1);
        chk("wait_rd_val", uart_rd, 32'h0000_00A5);
        repeat (2) @(negedge clk);
        chk("rd_hold", uart_rd, 32'h0000_00A5);

        // 17 random frames, no reads: overrun, then drain 16 in order.
        for (int i = 0; i < 17; i++) begin
            r = 8'($urandom);
            send_frame(r, 1'b1, t0);
        end
        repeat (8) @(negedge clk);
        chk("ovr_set", 32'(rx_overrun), 32'(model_ovr));
        chk("ovr_model", 32'(model_ovr), 32'd1);
        for (int i = 0; i < 16; i++) begin
            do_read();
            chk("drain_lat", 32'(uart_rdone), 32'd1);
        end
        repeat (4) @(negedge clk);

        // Randomized mixed traffic on both directions.
        fs = tx_frames;
        for (int i = 0; i < 6; i++) begin
            do_write(8'($urandom), lat, k);
            chk("rand_wlat", lat, 1);
            send_frame(8'($urandom), 1'b1, t0);
            repeat (2) @(negedge clk);
            do_read();
            chk("rand_rlat", 32'(uart_rdone), 32'd1);
        end
        wait_tx(fs + 6, 600);
        chk("rd_queue_empty", exp_rd.size(), 0);

        // Reset in the middle of a TX data bit with more bytes queued.
        for (int i = 0; i < 3; i++) do_write(8'($urandom), lat, k);
        k = 0;
        while (txd && k < 20) begin
            @(negedge clk);
            k++;
        end
        repeat (30) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_mid_txd", 32'(txd), 32'd1);
        chk("rst_mid_wdone", 32'(uart_wdone), 32'd0);
        exp_tx.delete();
        model_rx.delete();
        model_rd_pend = 1'b0;
        repeat (10) @(negedge clk);
        rstn = 1'b1;
        ws = wd_cnt;
        fs = tx_frames;
        repeat (120) @(negedge clk);
        chk("post_rst_wdone", wd_cnt, ws);
        chk("post_rst_frames", tx_frames, fs);
        chk("post_rst_txd", 32'(txd), 32'd1);
        chk("post_rst_ovr", 32'(rx_overrun), 32'd0);
        chk("post_rst_ferr", 32'(frame_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
